// File: rtl/maze_dfs_ctrl.sv
// maze_dfs_ctrl: depth-first maze solver controller.
// Walks a 2^ROW_BITS x 2^COL_BITS grid from cell 0 to the all-ones cell, using a
// 1-bit-per-cell external memory as the combined wall/visited map. The current path
// is kept in an internal stack so that it can be read back after a successful run.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               run request (accepted in IDLE/DONE/FAIL only)
//   mem_rd/mem_wr       maze memory strobes; read data returns on mem_rdata next cycle
//   mem_addr/mem_wdata  cell address, write data (always 1 = visited)
//   mem_rdata           1 = blocked (wall or visited)
//   curr_loc            current cell {row,col}
//   busy/done/fail      run status
//   path_len            stack occupancy
//   path_idx/path_loc   combinational stack readback
//   move_cnt            forward moves plus backtracks, saturating
module maze_dfs_ctrl #(
  parameter int unsigned ROW_BITS    = 4,
  parameter int unsigned COL_BITS    = 4,
  parameter int unsigned STACK_DEPTH = 256,
  localparam int unsigned LOC_W      = ROW_BITS + COL_BITS,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [LOC_W-1:0] mem_addr,
  output logic             mem_wdata,
  input  logic             mem_rdata,
  output logic [LOC_W-1:0] curr_loc,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [SP_W-1:0]  path_len,
  input  logic [SP_W-1:0]  path_idx,
  output logic [LOC_W-1:0] path_loc,
  output logic [15:0]      move_cnt
);

  localparam int unsigned STK_AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [LOC_W-1:0] GOAL    = {LOC_W{1'b1}};
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [2:0]       DIR_END = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_MARK, S_CHECK, S_PROBE, S_READ, S_EVAL, S_BACK, S_DONE, S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [LOC_W-1:0]  loc_q, loc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [2:0]        dir_q, dir_d;
  logic [15:0]       cnt_q, cnt_d, cnt_inc;
  logic              push_en;
  logic [LOC_W-1:0]  stack [STACK_DEPTH];
  logic [LOC_W-1:0]  stack_top;
  logic [LOC_W:0]    nbr;
  logic              nbr_ok;
  logic [LOC_W-1:0]  nbr_loc;
  logic              mem_rd_d, mem_wr_d, busy_d, done_d, fail_d;
  logic [LOC_W-1:0]  mem_addr_d;

  // Neighbour of loc in direction d as {in_grid, address}; no wrap-around.
  function automatic logic [LOC_W:0] nbr_of(input logic [LOC_W-1:0] loc, input logic [2:0] d);
    logic [ROW_BITS-1:0] r;
    logic [COL_BITS-1:0] c;
    logic                ok;
    r  = loc[LOC_W-1:COL_BITS];
    c  = loc[COL_BITS-1:0];
    ok = 1'b0;
    case (d)
      3'd0: begin ok = (c != {COL_BITS{1'b1}}); c = c + COL_BITS'(1); end
      3'd1: begin ok = (r != {ROW_BITS{1'b1}}); r = r + ROW_BITS'(1); end
      3'd2: begin ok = (c != '0);               c = c - COL_BITS'(1); end
      3'd3: begin ok = (r != '0);               r = r - ROW_BITS'(1); end
      default: ok = 1'b0;
    endcase
    return {ok, r, c};
  endfunction

  assign nbr       = nbr_of(loc_q, dir_q);
  assign nbr_ok    = nbr[LOC_W];
  assign nbr_loc   = nbr[LOC_W-1:0];
  assign stack_top = stack[STK_AW'(sp_q - SP_W'(1))];
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    loc_d   = loc_q;
    sp_d    = sp_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    push_en = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      S_INIT: begin
        loc_d   = '0;
        sp_d    = '0;
        state_d = S_MARK;
      end
      S_MARK:  state_d = S_CHECK;
      S_CHECK: begin
        if (loc_q == GOAL) begin
          state_d = S_DONE;
        end else begin
          dir_d   = '0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        if (dir_q >= DIR_END) state_d = S_BACK;
        else if (!nbr_ok)     dir_d   = dir_q + 3'd1;
        else                  state_d = S_READ;
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        if (mem_rdata) begin
          dir_d   = dir_q + 3'd1;
          state_d = S_PROBE;
        end else if (sp_q == SP_FULL) begin
          state_d = S_FAIL;
        end else begin
          push_en = 1'b1;
          loc_d   = nbr_loc;
          sp_d    = sp_q + SP_W'(1);
          cnt_d   = cnt_inc;
          state_d = S_MARK;
        end
      end
      S_BACK: begin
        if (sp_q == '0) begin
          state_d = S_FAIL;
        end else begin
          // Popped cell is already marked, so probing resumes directly.
          loc_d   = stack_top;
          sp_d    = sp_q - SP_W'(1);
          cnt_d   = cnt_inc;
          dir_d   = '0;
          state_d = S_PROBE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they register in step with it.
  always_comb begin
    mem_wr_d   = (state_d == S_MARK);
    mem_rd_d   = (state_d == S_READ);
    mem_addr_d = (state_d == S_READ) ? nbr_loc : loc_d;
    busy_d     = !(state_d inside {S_IDLE, S_DONE, S_FAIL});
    done_d     = (state_d == S_DONE);
    fail_d     = (state_d == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      loc_q    <= '0;
      sp_q     <= '0;
      dir_q    <= '0;
      cnt_q    <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state_q  <= state_d;
      loc_q    <= loc_d;
      sp_q     <= sp_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      mem_rd   <= mem_rd_d;
      mem_wr   <= mem_wr_d;
      mem_addr <= mem_addr_d;
      busy     <= busy_d;
      done     <= done_d;
      fail     <= fail_d;
    end
  end

  // Path stack storage; contents persist past DONE for readback.
  always_ff @(posedge clk) begin
    if (push_en && !rst) stack[STK_AW'(sp_q)] <= loc_q;
  end

  assign mem_wdata = 1'b1;
  assign curr_loc  = loc_q;
  assign path_len  = sp_q;
  assign move_cnt  = cnt_q;
  assign path_loc  = (path_idx < sp_q) ? stack[STK_AW'(path_idx)] : '0;

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// Testbench for maze_dfs_ctrl: three instances (2x2, 4x4, 4x4 with a 2-deep stack),
// each with a small maze memory model, checked against table constants and a DFS model.
module tb_maze_dfs_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 2x2
  logic        start_a, rd_a_s, wr_a_s, wdata_a, rdata_a, busy_a, done_a, fail_a;
  logic [1:0]  addr_a, curr_loc_a, path_loc_a;
  logic [8:0]  path_len_a, path_idx_a;
  logic [15:0] move_cnt_a;
  // Instance B: 4x4
  logic        start_b, rd_b_s, wr_b_s, wdata_b, rdata_b, busy_b, done_b, fail_b;
  logic [3:0]  addr_b, curr_loc_b, path_loc_b;
  logic [8:0]  path_len_b, path_idx_b;
  logic [15:0] move_cnt_b;
  // Instance C: 4x4, stack depth 2
  logic        start_c, rd_c_s, wr_c_s, wdata_c, rdata_c, busy_c, done_c, fail_c;
  logic [3:0]  addr_c, curr_loc_c, path_loc_c;
  logic [1:0]  path_len_c, path_idx_c;
  logic [15:0] move_cnt_c;

  maze_dfs_ctrl #(.ROW_BITS(1), .COL_BITS(1), .STACK_DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_rd(rd_a_s), .mem_wr(wr_a_s),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a), .curr_loc(curr_loc_a),
    .busy(busy_a), .done(done_a), .fail(fail_a), .path_len(path_len_a),
    .path_idx(path_idx_a), .path_loc(path_loc_a), .move_cnt(move_cnt_a));

  maze_dfs_ctrl #(.ROW_BITS(2), .COL_BITS(2), .STACK_DEPTH(256)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_rd(rd_b_s), .mem_wr(wr_b_s),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b), .curr_loc(curr_loc_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .path_len(path_len_b),
    .path_idx(path_idx_b), .path_loc(path_loc_b), .move_cnt(move_cnt_b));

  maze_dfs_ctrl #(.ROW_BITS(2), .COL_BITS(2), .STACK_DEPTH(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .mem_rd(rd_c_s), .mem_wr(wr_c_s),
    .mem_addr(addr_c), .mem_wdata(wdata_c), .mem_rdata(rdata_c), .curr_loc(curr_loc_c),
    .busy(busy_c), .done(done_c), .fail(fail_c), .path_len(path_len_c),
    .path_idx(path_idx_c), .path_loc(path_loc_c), .move_cnt(move_cnt_c));

  // Maze memories with access statistics (cleared on load).
  logic        load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;
  logic [3:0]  wall_a, mem_a, seen_a;
  logic [15:0] wall_b, mem_b, seen_b, wall_c, mem_c, seen_c;
  int wr_a = 0, rd_a = 0, dup_a = 0, both_a = 0;
  int wr_b = 0, rd_b = 0, dup_b = 0, both_b = 0;
  int wr_c = 0, rd_c = 0, dup_c = 0, both_c = 0;

  always @(posedge clk) begin
    if (load_a) begin
      mem_a <= wall_a; seen_a <= '0; wr_a <= 0; rd_a <= 0; dup_a <= 0; both_a <= 0;
    end else begin
      if (rd_a_s) begin rdata_a <= mem_a[addr_a]; rd_a <= rd_a + 1; end
      if (wr_a_s) begin
        mem_a[addr_a] <= wdata_a; seen_a[addr_a] <= 1'b1; wr_a <= wr_a + 1;
        if (seen_a[addr_a]) dup_a <= dup_a + 1;
      end
      if (rd_a_s && wr_a_s) both_a <= both_a + 1;
    end
  end

  always @(posedge clk) begin
    if (load_b) begin
      mem_b <= wall_b; seen_b <= '0; wr_b <= 0; rd_b <= 0; dup_b <= 0; both_b <= 0;
    end else begin
      if (rd_b_s) begin rdata_b <= mem_b[addr_b]; rd_b <= rd_b + 1; end
      if (wr_b_s) begin
        mem_b[addr_b] <= wdata_b; seen_b[addr_b] <= 1'b1; wr_b <= wr_b + 1;
        if (seen_b[addr_b]) dup_b <= dup_b + 1;
      end
      if (rd_b_s && wr_b_s) both_b <= both_b + 1;
    end
  end

  always @(posedge clk) begin
    if (load_c) begin
      mem_c <= wall_c; seen_c <= '0; wr_c <= 0; rd_c <= 0; dup_c <= 0; both_c <= 0;
    end else begin
      if (rd_c_s) begin rdata_c <= mem_c[addr_c]; rd_c <= rd_c + 1; end
      if (wr_c_s) begin
        mem_c[addr_c] <= wdata_c; seen_c[addr_c] <= 1'b1; wr_c <= wr_c + 1;
        if (seen_c[addr_c]) dup_c <= dup_c + 1;
      end
      if (rd_c_s && wr_c_s) both_c <= both_c + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference DFS: neighbour order east, south, west, north; returns results in m_*.
  bit m_done, m_fail;
  int m_len, m_moves, m_reads, m_writes, m_cur;
  int m_path[256];

  task automatic model(input logic [15:0] walls, input int rb, input int cb, input int depth);
    int cols, rows, goal, cur, found, nr, nc;
    bit seen[16];
    int stk[$];
    cols = 1 << cb; rows = 1 << rb; goal = rows * cols - 1;
    for (int i = 0; i < 16; i++) seen[i] = walls[i];
    cur = 0; seen[0] = 1'b1;
    m_writes = 1; m_reads = 0; m_moves = 0; m_done = 0; m_fail = 0;
    for (int step = 0; step < 4096; step++) begin
      if (cur == goal) begin m_done = 1; break; end
      found = -1;
      for (int d = 0; d < 4; d++) begin
        nr = cur / cols + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
        nc = cur % cols + ((d == 0) ? 1 : (d == 2) ? -1 : 0);
        if (nr >= 0 && nr < rows && nc >= 0 && nc < cols) begin
          m_reads++;
          if (!seen[nr * cols + nc]) begin found = nr * cols + nc; break; end
        end
      end
      if (found >= 0) begin
        if (stk.size() == depth) begin m_fail = 1; break; end
        stk.push_back(cur); cur = found; seen[cur] = 1'b1; m_writes++; m_moves++;
      end else begin
        if (stk.size() == 0) begin m_fail = 1; break; end
        cur = stk.pop_back(); m_moves++;
      end
    end
    m_cur = cur;
    m_len = stk.size();
    for (int i = 0; i < m_len; i++) m_path[i] = stk[i];
  endtask

  task automatic load(input int which, input logic [15:0] w);
    @(negedge clk);
    case (which)
      0: begin wall_a = w[3:0]; load_a = 1'b1; end
      1: begin wall_b = w;      load_b = 1'b1; end
      default: begin wall_c = w; load_c = 1'b1; end
    endcase
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_end(input int which);
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 5000 && !fin; i++) begin
      @(negedge clk);
      case (which)
        0: fin = done_a | fail_a;
        1: fin = done_b | fail_b;
        default: fin = done_c | fail_c;
      endcase
    end
    if (!fin) chk("run_timeout", 0, 1);
  endtask

  // Full run on the 4x4 instance, compared against the reference model.
  task automatic run_b(input logic [15:0] w);
    load(1, w);
    model(w, 2, 2, 256);
    pulse(1);
    wait_end(1);
    chk("b_done", done_b, m_done);
    chk("b_fail", fail_b, m_fail);
    chk("b_busy", busy_b, 0);
    chk("b_path_len", path_len_b, m_len);
    chk("b_move_cnt", move_cnt_b, m_moves);
    chk("b_curr_loc", curr_loc_b, m_cur);
    for (int i = 0; i < m_len; i++) begin
      path_idx_b = 9'(i);
      #1;
      chk("b_path_loc", path_loc_b, m_path[i]);
    end
    chk("b_reads", rd_b, m_reads);
    chk("b_writes", wr_b, m_writes);
    chk("b_dup_writes", dup_b, 0);
    chk("b_rd_wr_overlap", both_b, 0);
  endtask

  typedef struct {
    logic [15:0] walls;
    bit          exp_done;
    int          exp_len;
    int          exp_moves;
    int          exp_cur;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{16'h0000, 1'b1, 6, 6, 15};  // open grid
    tbl[1] = '{16'h00A4, 1'b1, 6, 8, 15};  // dead end at cell 1 forces one backtrack
    tbl[2] = '{16'h4800, 1'b0, 0, 24, 0};  // goal enclosed: full exploration then fail
    tbl[3] = '{16'h0012, 1'b0, 0, 0, 0};   // start boxed in
    tbl[4] = '{16'h000E, 1'b1, 6, 6, 15};  // top row walled

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    path_idx_a = '0; path_idx_b = '0; path_idx_c = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", busy_b, 0);
    chk("rst_done", done_b, 0);
    chk("rst_fail", fail_b, 0);
    chk("rst_move_cnt", move_cnt_b, 0);
    chk("rst_path_len", path_len_b, 0);
    chk("rst_curr_loc", curr_loc_b, 0);
    chk("rst_mem_rd", rd_b_s, 0);
    chk("rst_mem_wr", wr_b_s, 0);

    // 2x2 open grid
    load(0, 16'h0000);
    pulse(0);
    wait_end(0);
    chk("a_done", done_a, 1);
    chk("a_fail", fail_a, 0);
    chk("a_path_len", path_len_a, 2);
    path_idx_a = 9'd0; #1; chk("a_path_loc0", path_loc_a, 0);
    path_idx_a = 9'd1; #1; chk("a_path_loc1", path_loc_a, 1);
    chk("a_curr_loc", curr_loc_a, 3);
    chk("a_move_cnt", move_cnt_a, 2);
    chk("a_writes", wr_a, 3);
    chk("a_reads", rd_a, 2);

    // 2x2 with cells 01 and 10 walled
    load(0, 16'h0006);
    pulse(0);
    wait_end(0);
    chk("a_wall_fail", fail_a, 1);
    chk("a_wall_done", done_a, 0);
    chk("a_wall_busy", busy_a, 0);
    chk("a_wall_path_len", path_len_a, 0);
    chk("a_wall_move_cnt", move_cnt_a, 0);

    // Directed 4x4 table
    for (int t = 0; t < 5; t++) begin
      run_b(tbl[t].walls);
      chk("tbl_done", done_b, tbl[t].exp_done);
      chk("tbl_fail", fail_b, !tbl[t].exp_done);
      chk("tbl_path_len", path_len_b, tbl[t].exp_len);
      chk("tbl_move_cnt", move_cnt_b, tbl[t].exp_moves);
      chk("tbl_curr_loc", curr_loc_b, tbl[t].exp_cur);
    end

    // Stack overflow on a 2-deep stack
    load(2, 16'h0000);
    pulse(2);
    wait_end(2);
    chk("c_fail", fail_c, 1);
    chk("c_done", done_c, 0);
    chk("c_path_len", path_len_c, 2);
    chk("c_curr_loc", curr_loc_c, 2);
    chk("c_move_cnt", move_cnt_c, 2);
    path_idx_c = 2'd0; #1; chk("c_path_loc0", path_loc_c, 0);
    path_idx_c = 2'd1; #1; chk("c_path_loc1", path_loc_c, 1);

    // Reset while a read is in flight, then a clean rerun
    load(1, 16'h00A4);
    pulse(1);
    begin
      bit seen_rd;
      seen_rd = 1'b0;
      for (int i = 0; i < 200 && !seen_rd; i++) begin
        if (rd_b_s) seen_rd = 1'b1;
        else @(negedge clk);
      end
      chk("mid_reached_read", seen_rd, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy_b, 0);
    chk("mid_rst_done", done_b, 0);
    chk("mid_rst_fail", fail_b, 0);
    chk("mid_rst_mem_rd", rd_b_s, 0);
    chk("mid_rst_mem_wr", wr_b_s, 0);
    chk("mid_rst_curr_loc", curr_loc_b, 0);
    chk("mid_rst_path_len", path_len_b, 0);
    chk("mid_rst_move_cnt", move_cnt_b, 0);
    run_b(16'h00A4);

    // Start while busy is ignored
    load(1, 16'h00A4);
    pulse(1);
    repeat (6) @(negedge clk);
    chk("busy_before_restart", busy_b, 1);
    pulse(1);
    wait_end(1);
    chk("ignore_done", done_b, 1);
    chk("ignore_move_cnt", move_cnt_b, 8);
    chk("ignore_dup_writes", dup_b, 0);

    // Start from DONE clears done and runs again
    load(1, 16'h00A4);
    pulse(1);
    chk("redo_done_cleared", done_b, 0);
    chk("redo_busy", busy_b, 1);
    wait_end(1);
    chk("redo_done", done_b, 1);
    chk("redo_move_cnt", move_cnt_b, 8);

    // Random mazes against the reference model
    for (int k = 0; k < 30; k++) begin
      logic [15:0] w;
      w = 16'($urandom & $urandom);
      w[0] = 1'b0;
      w[15] = 1'b0;
      run_b(w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
